mmio_tx_responder: RTL and testbench

Memory-mapped responder on the CPU data/instruction memory bus, alongside Memoria. It decodes a 16-byte window at BASE_ADDR. It provides a byte transmit FIFO drained through a valid/ready stream, a status register, a control register and a free-running cycle counter. Reads use the same one-cycle latency as Memoria, so the CPU top selects between the two with the registered hit flag.

---
 rtl/mmio_tx_responder.sv | 91 +++++++++
 tb/tb_mmio_tx_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mmio_tx_responder.sv
// mmio_tx_responder: MMIO window with byte TX FIFO, STATUS, CYCLE and CTRL registers.
// Define MMIO_TX_IRQ_EN to enable the registered irq output and CTRL bit1.
module mmio_tx_responder #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter int DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0] mem [DEPTH];
    logic [AW-1:0] rdPtr, wrPtr;
    logic [AW:0] count;
    logic [31:0] cycleCount, regValue;
    logic [4:0] countField;
    logic [1:0] idx;
    logic sel, wrSel, full, empty, push, pop, doPush, overflow, drainEn, irqEn;
    logic unusedBits;

    assign sel = addr[31:4] == BASE_ADDR[31:4];
    assign wrSel = sel && wr;
    assign idx = addr[3:2];
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign push = wrSel && idx == 2'd0;
    assign pop = tx_valid && tx_ready;
    assign doPush = push && !full;
    assign tx_valid = drainEn && !empty;
    assign tx_data = mem[rdPtr];
    assign countField = (32'(count) > 32'd31) ? 5'd31 : 5'(count);
    assign unusedBits = ^{addr[1:0], wdata[31:8]};

    always_comb begin
        regValue = idx == 2'd1 ? {19'd0, countField, 5'd0, overflow, empty, full} :
                   idx == 2'd2 ? cycleCount :
                   idx == 2'd3 ? {30'd0, irqEn, drainEn} : 32'd0;
    end

    // Storage is intentionally not reset; stale bytes are unreachable while empty.
    always_ff @(posedge clock) begin
        if (!reset && doPush) mem[wrPtr] <= wdata[7:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
            overflow <= 1'b0;
            cycleCount <= 32'd0;
            drainEn <= 1'b1;
            rdata <= 32'd0;
            hit <= 1'b0;
        end else begin
            rdata <= (sel && !wr) ? regValue : 32'd0;
            hit <= sel && !wr;
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (pop) rdPtr <= rdPtr + 1'b1;
            count <= count + (AW+1)'(doPush) - (AW+1)'(pop);
            if (push && full) overflow <= 1'b1;
            else if (wrSel && idx == 2'd1 && wdata[2]) overflow <= 1'b0;
            cycleCount <= (wrSel && idx == 2'd2) ? 32'd0 : cycleCount + 32'd1;
            if (wrSel && idx == 2'd3) drainEn <= wdata[0];
        end
    end

`ifdef MMIO_TX_IRQ_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            irqEn <= 1'b0;
            irq <= 1'b0;
        end else begin
            if (wrSel && idx == 2'd3) irqEn <= wdata[1];
            irq <= irqEn && (empty || overflow);
        end
    end
`else
    assign irqEn = 1'b0;
    assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_mmio_tx_responder.sv
// tb_mmio_tx_responder: scoreboard bench for mmio_tx_responder (default DEPTH=8).
module tb_mmio_tx_responder;
    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam logic [31:0] TXD = BASE, STAT = BASE + 32'h4, CYC = BASE + 32'h8, CTRL = BASE + 32'hC;

    logic clock = 1'b0, reset = 1'b1, wr = 1'b0, tx_ready = 1'b0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic [31:0] rdata;
    logic hit, tx_valid, irq;
    logic [7:0] tx_data;

    always #5 clock = ~clock;

    mmio_tx_responder dut (
        .clock(clock), .reset(reset), .addr(addr), .wr(wr), .wdata(wdata),
        .rdata(rdata), .hit(hit), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .irq(irq)
    );

    typedef struct {
        string tag;
        logic [31:0] data;
        logic h;
    } readExp_t;

    readExp_t readQ[$];
    logic [7:0] txQ[$];
    int nChecks = 0, nFails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #2;
    endtask

    task automatic idle;
        addr = 32'd0;
        wr = 1'b0;
        wdata = 32'd0;
    endtask

    task automatic popCheck;
        readExp_t e;
        e = readQ.pop_front();
        check({e.tag, "_hit"}, 32'(hit), 32'(e.h));
        check({e.tag, "_rdata"}, rdata, e.data);
    endtask

    task automatic busRead(input logic [31:0] a, input logic [31:0] d, input logic h, input string tag);
        addr = a;
        wr = 1'b0;
        readQ.push_back('{tag, d, h});
        tick;
        popCheck;
        idle;
    endtask

    task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
        addr = a;
        wr = 1'b1;
        wdata = d;
        tick;
        idle;
    endtask

    task automatic pushByte(input logic [7:0] b, input logic accepted);
        if (accepted) txQ.push_back(b);
        busWrite(TXD, {24'd0, b});
    endtask

    // Stream monitor: a handshake seen mid-cycle completes at the next edge.
    always @(negedge clock) begin
        if (!reset && tx_valid && tx_ready) begin
            if (txQ.size() == 0) check("tx_extra", 32'(txQ.size()), 32'd1);
            else check("tx_data", 32'(tx_data), 32'(txQ.pop_front()));
        end
    end

    initial begin
        repeat (3) tick;
        check("rst_rdata", rdata, 32'd0);
        check("rst_hit", 32'(hit), 32'd0);
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        reset = 1'b0;
        busRead(STAT, 32'h2, 1'b1, "status_reset");
        busRead(CTRL, 32'h1, 1'b1, "ctrl_reset");
        busRead(BASE + 32'h10, 32'h0, 1'b0, "outside");

        for (int i = 0; i < 3; i++) pushByte(8'h41 + 8'(i), 1'b1);
        busRead(STAT, 32'h300, 1'b1, "status_three");
        check("valid_three", 32'(tx_valid), 32'd1);
        check("head_three", 32'(tx_data), 32'h41);
        tx_ready = 1'b1;
        repeat (3) tick;
        tx_ready = 1'b0;
        check("valid_drained", 32'(tx_valid), 32'd0);
        check("q_drained", 32'(txQ.size()), 32'd0);
        busRead(STAT, 32'h2, 1'b1, "status_drained");

        for (int i = 0; i < 9; i++) pushByte(8'h50 + 8'(i), i < 8);
        busRead(STAT, 32'h805, 1'b1, "status_ovf");
        check("head_full", 32'(tx_data), 32'h50);
        busWrite(STAT, 32'h4);
        busRead(STAT, 32'h801, 1'b1, "status_ovf_clr");

        tx_ready = 1'b1;
        busWrite(TXD, 32'h99);
        tx_ready = 1'b0;
        busRead(STAT, 32'h704, 1'b1, "status_full_pop");
        pushByte(8'h60, 1'b1);
        busRead(STAT, 32'h805, 1'b1, "status_refill");
        tx_ready = 1'b1;
        repeat (8) tick;
        tx_ready = 1'b0;
        check("valid_refill", 32'(tx_valid), 32'd0);
        check("q_refill", 32'(txQ.size()), 32'd0);
        busWrite(STAT, 32'h4);
        busRead(STAT, 32'h2, 1'b1, "status_clean");

        busWrite(CYC, 32'hDEAD_BEEF);
        repeat (5) tick;
        busRead(CYC, 32'd5, 1'b1, "cycle_5");
        addr = CYC;
        wr = 1'b0;
        force dut.cycleCount = 32'hFFFF_FFFF;
        #1;
        release dut.cycleCount;
        readQ.push_back('{"cycle_max", 32'hFFFF_FFFF, 1'b1});
        tick;
        popCheck;
        readQ.push_back('{"cycle_wrap", 32'h0, 1'b1});
        tick;
        popCheck;
        idle;

        busWrite(CTRL, 32'h0);
        pushByte(8'h77, 1'b1);
        check("valid_nodrain", 32'(tx_valid), 32'd0);
        busRead(STAT, 32'h100, 1'b1, "status_nodrain");
        busWrite(CTRL, 32'h1);
        check("valid_drain", 32'(tx_valid), 32'd1);
        check("head_drain", 32'(tx_data), 32'h77);
        tx_ready = 1'b1;
        tick;
        tx_ready = 1'b0;
        check("valid_after_drain", 32'(tx_valid), 32'd0);

`ifdef MMIO_TX_IRQ_EN
        busWrite(CTRL, 32'h3);
        check("irq_lag", 32'(irq), 32'd0);
        tick;
        check("irq_on", 32'(irq), 32'd1);
        busRead(CTRL, 32'h3, 1'b1, "ctrl_irq");
        pushByte(8'h88, 1'b1);
        tick;
        check("irq_off", 32'(irq), 32'd0);
        tx_ready = 1'b1;
        tick;
        tx_ready = 1'b0;
`else
        busWrite(CTRL, 32'h3);
        tick;
        check("irq_tied", 32'(irq), 32'd0);
        busRead(CTRL, 32'h1, 1'b1, "ctrl_noirq");
`endif

        pushByte(8'hA1, 1'b1);
        pushByte(8'hA2, 1'b1);
        addr = STAT;
        wr = 1'b0;
        reset = 1'b1;
        tick;
        check("midrst_rdata", rdata, 32'd0);
        check("midrst_hit", 32'(hit), 32'd0);
        check("midrst_valid", 32'(tx_valid), 32'd0);
        reset = 1'b0;
        idle;
        txQ.delete();
        busRead(STAT, 32'h2, 1'b1, "status_midrst");
        busRead(CTRL, 32'h1, 1'b1, "ctrl_midrst");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
